// File: rtl/rf2p_banked_pkg.sv
// Shared types for the banked two-port register file: generation mode, FSM state and
// the elaboration-time parameter sanity check.
package RFCfg;

  typedef enum logic [1:0] {SIM, FPGA, SYN} GenMode;

  typedef enum logic [0:0] {RF_INIT, RF_READY} rf_state_e;

  // True when the geometry cannot be built (no channels or a single-word array).
  function automatic bit ErrorRF(int unsigned nch, int unsigned wordwd);
    return (nch < 1) || (wordwd < 2);
  endfunction

endpackage

// File: rtl/rf2p_bank.sv
// One channel of register-file storage: DWD wide, WORDWD deep, one write and one
// combinational read port. The owner registers the read data.
module rf2p_bank
  import RFCfg::*;
#(
  parameter int unsigned WORDWD   = 64,
  parameter int unsigned DWD      = 16,
  parameter GenMode      gen_mode = SIM
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [$clog2(WORDWD)-1:0] waddr_i,
  input  logic [DWD-1:0]            wdata_i,
  input  logic [$clog2(WORDWD)-1:0] raddr_i,
  output logic [DWD-1:0]            rdata_o
);

  localparam int unsigned AWD = $clog2(WORDWD);

  logic [DWD-1:0] mem [WORDWD];

  if (gen_mode == SYN) begin : gen_macro
    // Per-word enabled flops: the structure the RF macro flow maps onto.
    for (genvar w = 0; w < WORDWD; w++) begin : gen_word
      always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i == AWD'(w))) begin
          mem[w] <= wdata_i;
        end
      end
    end
  end else begin : gen_behav
    always_ff @(posedge clk_i) begin
      if (we_i) begin
        mem[waddr_i] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/rf2p_banked.sv
// NCH-channel two-port register file with per-channel write mask, registered read and a
// post-reset zeroing sweep. Define RF2P_BYPASS_EN for write-first same-address reads.
module rf2p_banked
  import RFCfg::*;
#(
  parameter int unsigned WORDWD   = 64,
  parameter int unsigned DWD      = 16,
  parameter int unsigned NCH      = 4,
  parameter GenMode      gen_mode = SIM
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_read,
  input  logic [$clog2(WORDWD)-1:0]     i_raddr,
  input  logic                          i_write,
  input  logic [$clog2(WORDWD)-1:0]     i_waddr,
  input  logic [NCH-1:0]                i_wmsk,
  input  logic [NCH-1:0][DWD-1:0]       i_wdata,
  output logic [NCH-1:0][DWD-1:0]       o_rdata,
  output logic                          o_rvalid,
  output logic                          o_ready
);

  localparam int unsigned    AWD      = $clog2(WORDWD);
  localparam logic [AWD:0]   Depth    = (AWD+1)'(WORDWD);
  localparam logic [AWD-1:0] LastAddr = AWD'(WORDWD - 1);

  if (ErrorRF(NCH, WORDWD)) begin : gen_cfg_err
    $error("rf2p_banked: NCH must be >= 1 and WORDWD >= 2");
  end

  rf_state_e                state_q, state_d;
  logic [AWD-1:0]           init_cnt_q;
  logic                     init_active, init_last;
  logic                     waddr_ok, raddr_ok, wr_acc, rd_acc;
  logic [AWD-1:0]           bank_waddr;
  logic [NCH-1:0]           bank_we;
  logic [NCH-1:0][DWD-1:0]  bank_wdata, bank_rdata, rd_word;
  logic [NCH-1:0][DWD-1:0]  rdata_q;
  logic                     rvalid_q;

  // FSM: state register, next state, outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RF_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RF_INIT:  if (init_last) state_d = RF_READY;
      RF_READY: state_d = RF_READY;
    endcase
  end

  always_comb begin
    init_active = 1'b0;
    o_ready     = 1'b0;
    unique case (state_q)
      RF_INIT:  init_active = 1'b1;
      RF_READY: o_ready     = 1'b1;
    endcase
  end

  assign init_last = (init_cnt_q == LastAddr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      init_cnt_q <= '0;
    end else if (init_active) begin
      init_cnt_q <= init_cnt_q + AWD'(1);
    end
  end

  assign waddr_ok = ({1'b0, i_waddr} < Depth);
  assign raddr_ok = ({1'b0, i_raddr} < Depth);
  assign wr_acc   = i_write & o_ready & waddr_ok;
  assign rd_acc   = i_read & o_ready;

  // The sweep owns the write port until every word has been zeroed.
  always_comb begin
    bank_waddr = init_active ? init_cnt_q : i_waddr;
    for (int unsigned c = 0; c < NCH; c++) begin
      bank_we[c]    = init_active | (wr_acc & i_wmsk[c]);
      bank_wdata[c] = init_active ? '0 : i_wdata[c];
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : gen_bank
    rf2p_bank #(
      .WORDWD   (WORDWD),
      .DWD      (DWD),
      .gen_mode (gen_mode)
    ) u_bank (
      .clk_i   (i_clk),
      .we_i    (bank_we[c]),
      .waddr_i (bank_waddr),
      .wdata_i (bank_wdata[c]),
      .raddr_i (i_raddr),
      .rdata_o (bank_rdata[c])
    );
  end

`ifdef RF2P_BYPASS_EN
  logic collide;
  assign collide = wr_acc & (i_raddr == i_waddr);

  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      rd_word[c] = (collide & i_wmsk[c]) ? i_wdata[c] : bank_rdata[c];
    end
  end
`else
  // Array is read before the edge commits the write, so collisions are read-first.
  assign rd_word = bank_rdata;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        rdata_q <= raddr_ok ? rd_word : '0;
      end
    end
  end

  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;

endmodule

// File: tb/tb_rf2p_banked.sv
// Directed bench for rf2p_banked: a 16-word and a 12-word instance share all inputs.
module tb_rf2p_banked;

  localparam int unsigned NCH = 4;
  localparam int unsigned DWD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n, read, write;
  logic [3:0]              raddr, waddr, wmsk;
  logic [NCH-1:0][DWD-1:0] wdata, rdata16, rdata12, exp_w;
  logic                    rvalid16, ready16, rvalid12, ready12;
  int                      n_checks = 0;
  int                      n_fail   = 0;

  rf2p_banked #(.WORDWD(16), .DWD(DWD), .NCH(NCH)) dut16 (
    .i_clk (clk), .i_rst_n (rst_n), .i_read (read), .i_raddr (raddr), .i_write (write),
    .i_waddr (waddr), .i_wmsk (wmsk), .i_wdata (wdata), .o_rdata (rdata16),
    .o_rvalid (rvalid16), .o_ready (ready16)
  );

  rf2p_banked #(.WORDWD(12), .DWD(DWD), .NCH(NCH)) dut12 (
    .i_clk (clk), .i_rst_n (rst_n), .i_read (read), .i_raddr (raddr), .i_write (write),
    .i_waddr (waddr), .i_wmsk (wmsk), .i_wdata (wdata), .o_rdata (rdata12),
    .o_rvalid (rvalid12), .o_ready (ready12)
  );

  task automatic idle();
    read = 1'b0; write = 1'b0; raddr = '0; waddr = '0; wmsk = '0; wdata = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (rdata16 !== '0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata16); end
    n_checks++; if (rvalid16 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b exp 0", rvalid16); end
    n_checks++; if (ready16 !== 1'b0) begin n_fail++; $display("FAIL reset_ready16 got %b exp 0", ready16); end
    n_checks++; if (ready12 !== 1'b0) begin n_fail++; $display("FAIL reset_ready12 got %b exp 0", ready12); end
    // Requests during the sweep must be ignored.
    rst_n = 1'b1; read = 1'b1; raddr = 4'd0;
    write = 1'b1; waddr = 4'd0; wmsk = 4'b1111; wdata = {4{16'hFFFF}};
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 11) write = 1'b0;
      n_checks++;
      if (ready16 !== (k >= 16)) begin
        n_fail++; $display("FAIL init_ready16 k=%0d got %b exp %b", k, ready16, (k >= 16));
      end
      n_checks++;
      if (ready12 !== (k >= 12)) begin
        n_fail++; $display("FAIL init_ready12 k=%0d got %b exp %b", k, ready12, (k >= 12));
      end
      n_checks++;
      if (rvalid16 !== 1'b0) begin
        n_fail++; $display("FAIL init_rvalid16 k=%0d got %b exp 0", k, rvalid16);
      end
      n_checks++;
      if (rvalid12 !== (k >= 13)) begin
        n_fail++; $display("FAIL init_rvalid12 k=%0d got %b exp %b", k, rvalid12, (k >= 13));
      end
    end
  endtask

  task automatic test_read_all();
    for (int a = 0; a < 16; a++) begin
      read = 1'b1; raddr = 4'(a);
      @(negedge clk);
      n_checks++;
      if (rvalid16 !== 1'b1 || rdata16 !== '0) begin
        n_fail++; $display("FAIL sweep_read16 a=%0d got v=%b d=%h exp v=1 d=0", a, rvalid16, rdata16);
      end
      n_checks++;
      if (rvalid12 !== 1'b1 || rdata12 !== '0) begin
        n_fail++; $display("FAIL sweep_read12 a=%0d got v=%b d=%h exp v=1 d=0", a, rvalid12, rdata12);
      end
    end
    idle();
    @(negedge clk);
    n_checks++; if (rvalid16 !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid got %b exp 0", rvalid16); end
  endtask

  task automatic test_masked_write();
    write = 1'b1; waddr = 4'd5; wmsk = 4'b1010;
    wdata = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    @(negedge clk);
    idle(); read = 1'b1; raddr = 4'd5;
    @(negedge clk);
    exp_w = {16'hAAAA, 16'h0000, 16'hCCCC, 16'h0000};
    n_checks++; if (rdata16 !== exp_w) begin n_fail++; $display("FAIL mask_1010 got %h exp %h", rdata16, exp_w); end
    n_checks++; if (rvalid16 !== 1'b1) begin n_fail++; $display("FAIL mask_rvalid got %b exp 1", rvalid16); end
    idle(); write = 1'b1; waddr = 4'd5; wmsk = 4'b0101;
    wdata = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    @(negedge clk);
    idle(); read = 1'b1; raddr = 4'd5;
    @(negedge clk);
    exp_w = {16'hAAAA, 16'h2222, 16'hCCCC, 16'h4444};
    n_checks++; if (rdata16 !== exp_w) begin n_fail++; $display("FAIL mask_0101 got %h exp %h", rdata16, exp_w); end
    n_checks++; if (rdata12 !== exp_w) begin n_fail++; $display("FAIL mask_0101_12 got %h exp %h", rdata12, exp_w); end
    idle();
  endtask

  task automatic test_collision();
    write = 1'b1; waddr = 4'd3; wmsk = 4'b1111; wdata = {4{16'h1234}};
    read = 1'b1; raddr = 4'd3;
    @(negedge clk);
`ifdef RF2P_BYPASS_EN
    exp_w = {4{16'h1234}};
`else
    exp_w = '0;
`endif
    n_checks++; if (rdata16 !== exp_w) begin n_fail++; $display("FAIL collide_full got %h exp %h", rdata16, exp_w); end
    n_checks++; if (rdata12 !== exp_w) begin n_fail++; $display("FAIL collide_full12 got %h exp %h", rdata12, exp_w); end
    write = 1'b1; waddr = 4'd3; wmsk = 4'b0011; wdata = {4{16'h5678}};
    @(negedge clk);
`ifdef RF2P_BYPASS_EN
    exp_w = {16'h1234, 16'h1234, 16'h5678, 16'h5678};
`else
    exp_w = {4{16'h1234}};
`endif
    n_checks++; if (rdata16 !== exp_w) begin n_fail++; $display("FAIL collide_part got %h exp %h", rdata16, exp_w); end
    write = 1'b0;
    @(negedge clk);
    exp_w = {16'h1234, 16'h1234, 16'h5678, 16'h5678};
    n_checks++; if (rdata16 !== exp_w) begin n_fail++; $display("FAIL collide_after got %h exp %h", rdata16, exp_w); end
    idle();
  endtask

  task automatic test_back_to_back();
    write = 1'b1; wmsk = 4'b1111; waddr = 4'd1;
    wdata = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    @(negedge clk);
    waddr = 4'd2; wdata = {16'h2003, 16'h2002, 16'h2001, 16'h2000};
    @(negedge clk);
    idle(); read = 1'b1; raddr = 4'd1;
    @(negedge clk);
    exp_w = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    n_checks++;
    if (rvalid16 !== 1'b1 || rdata16 !== exp_w) begin
      n_fail++; $display("FAIL b2b_rd1 got v=%b d=%h exp v=1 d=%h", rvalid16, rdata16, exp_w);
    end
    raddr = 4'd2;
    @(negedge clk);
    exp_w = {16'h2003, 16'h2002, 16'h2001, 16'h2000};
    n_checks++;
    if (rvalid16 !== 1'b1 || rdata16 !== exp_w) begin
      n_fail++; $display("FAIL b2b_rd2 got v=%b d=%h exp v=1 d=%h", rvalid16, rdata16, exp_w);
    end
    raddr = 4'd3;
    @(negedge clk);
    exp_w = {16'h1234, 16'h1234, 16'h5678, 16'h5678};
    n_checks++;
    if (rvalid16 !== 1'b1 || rdata16 !== exp_w) begin
      n_fail++; $display("FAIL b2b_rd3 got v=%b d=%h exp v=1 d=%h", rvalid16, rdata16, exp_w);
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (rvalid16 !== 1'b0 || rdata16 !== exp_w) begin
        n_fail++; $display("FAIL hold_%0d got v=%b d=%h exp v=0 d=%h", i, rvalid16, rdata16, exp_w);
      end
    end
  endtask

  task automatic test_out_of_range();
    write = 1'b1; wmsk = 4'b1111; waddr = 4'd11;
    wdata = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
    @(negedge clk);
    waddr = 4'd13; wdata = {4{16'hDEAD}};
    @(negedge clk);
    idle(); read = 1'b1; raddr = 4'd11;
    @(negedge clk);
    exp_w = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
    n_checks++; if (rdata12 !== exp_w) begin n_fail++; $display("FAIL oor_addr11 got %h exp %h", rdata12, exp_w); end
    raddr = 4'd13;
    @(negedge clk);
    n_checks++;
    if (rvalid12 !== 1'b1 || rdata12 !== '0) begin
      n_fail++; $display("FAIL oor_read13 got v=%b d=%h exp v=1 d=0", rvalid12, rdata12);
    end
    exp_w = {4{16'hDEAD}};
    n_checks++; if (rdata16 !== exp_w) begin n_fail++; $display("FAIL inrange16_13 got %h exp %h", rdata16, exp_w); end
    idle();
  endtask

  task automatic test_reset_mid();
    read = 1'b1; raddr = 4'd11;
    repeat (2) @(negedge clk);
    exp_w = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
    n_checks++; if (rdata16 !== exp_w) begin n_fail++; $display("FAIL pre_rst got %h exp %h", rdata16, exp_w); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rdata16 !== '0 || rvalid16 !== 1'b0 || ready16 !== 1'b0) begin
      n_fail++; $display("FAIL async_rst got d=%h v=%b r=%b exp 0/0/0", rdata16, rvalid16, ready16);
    end
    n_checks++; if (rdata12 !== '0) begin n_fail++; $display("FAIL async_rst12 got %h exp 0", rdata12); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      n_checks++;
      if (ready16 !== (k >= 16) || rvalid16 !== 1'b0) begin
        n_fail++; $display("FAIL reinit k=%0d got r=%b v=%b exp r=%b v=0", k, ready16, rvalid16, (k >= 16));
      end
    end
    @(negedge clk);
    n_checks++;
    if (rvalid16 !== 1'b1 || rdata16 !== '0) begin
      n_fail++; $display("FAIL rst_clear11 got v=%b d=%h exp v=1 d=0", rvalid16, rdata16);
    end
    n_checks++; if (rdata12 !== '0) begin n_fail++; $display("FAIL rst_clear11_12 got %h exp 0", rdata12); end
    raddr = 4'd5;
    @(negedge clk);
    n_checks++; if (rdata16 !== '0) begin n_fail++; $display("FAIL rst_clear5 got %h exp 0", rdata16); end
    idle();
  endtask

  initial begin
    test_reset();
    test_read_all();
    test_masked_write();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1);
  end

endmodule
